// File: rtl/axi_ram_init_gate_pkg.sv
// axi_ram_init_gate_pkg: gate state encoding, error-responder write phases, SLVERR code and counter width
package axi_ram_init_gate_pkg;
  typedef enum logic [1:0] {WAIT_INIT = 2'b00, RUN = 2'b01, ERROR = 2'b10} gate_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'b00, W_DATA = 2'b01, W_RESP = 2'b10} wr_phase_t;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int CNT_W = 8;
endpackage

// File: rtl/axi_ram_init_gate_err.sv
// axi_err_slave: local AXI4 responder answering one read and one write burst at a time with SLVERR
module axi_err_slave
  import axi_ram_init_gate_pkg::*;
#(
  parameter int ID_WIDTH   = 6,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_core,
  input  logic                  rst_core,
  input  logic                  en,
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [7:0]            s_arlen,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  input  logic [ID_WIDTH-1:0]   s_awid,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [ID_WIDTH-1:0]   s_bid,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready
);
  logic                rd_busy;
  logic [7:0]          rd_left;
  logic [ID_WIDTH-1:0] rd_id;
  logic [ID_WIDTH-1:0] wr_id;
  wr_phase_t           wr_phase;

  assign s_arready = en && !rd_busy;
  assign s_rvalid  = en && rd_busy;
  assign s_rid     = rd_id;
  assign s_rdata   = '0;
  assign s_rresp   = RESP_SLVERR;
  assign s_rlast   = rd_busy && rd_left == 8'd0;
  assign s_awready = en && wr_phase == W_IDLE;
  assign s_wready  = en && wr_phase == W_DATA;
  assign s_bvalid  = en && wr_phase == W_RESP;
  assign s_bid     = wr_id;
  assign s_bresp   = RESP_SLVERR;

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      rd_busy  <= 1'b0;
      rd_left  <= '0;
      rd_id    <= '0;
      wr_id    <= '0;
      wr_phase <= W_IDLE;
    end else begin
      if (s_arvalid && s_arready) begin
        rd_busy <= 1'b1;
        rd_left <= s_arlen;
        rd_id   <= s_arid;
      end else if (s_rvalid && s_rready) begin
        rd_busy <= rd_left != 8'd0;
        rd_left <= rd_left - 8'd1;
      end
      if (s_awvalid && s_awready) begin
        wr_phase <= W_DATA;
        wr_id    <= s_awid;
      end else if (s_wvalid && s_wready && s_wlast) begin
        wr_phase <= W_RESP;
      end else if (s_bvalid && s_bready) begin
        wr_phase <= W_IDLE;
      end
    end
  end
endmodule

// File: rtl/axi_ram_init_gate.sv
// axi_ram_init_gate: holds AXI off until DRAM init, caps outstanding bursts in RUN, answers SLVERR on init failure (INIT_TIMEOUT_EN adds an init timeout)
module axi_ram_init_gate
  import axi_ram_init_gate_pkg::*;
#(
  parameter int          ID_WIDTH       = 6,
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 64,
  parameter int          MAX_OUT        = 15,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic                    clk_core,
  input  logic                    rst_core,
  input  logic                    i_ram_init_done,
  input  logic                    i_ram_init_error,
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ID_WIDTH-1:0]     s_arid,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [7:0]              s_arlen,
  input  logic [2:0]              s_arsize,
  input  logic [1:0]              s_arburst,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [ID_WIDTH-1:0]     s_rid,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [ID_WIDTH-1:0]     m_awid,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [ID_WIDTH-1:0]     m_bid,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ID_WIDTH-1:0]     m_arid,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [ID_WIDTH-1:0]     m_rid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic [1:0]              o_state,
  output logic                    o_timeout
);
  gate_state_t           state;
  logic [CNT_W-1:0]      rd_cnt;
  logic [CNT_W-1:0]      wr_cnt;
  logic                  run;
  logic                  err;
  logic                  rd_full;
  logic                  wr_full;
  logic                  ar_hs;
  logic                  r_end;
  logic                  aw_hs;
  logic                  b_end;
  logic                  e_arready;
  logic [ID_WIDTH-1:0]   e_rid;
  logic [DATA_WIDTH-1:0] e_rdata;
  logic [1:0]            e_rresp;
  logic                  e_rlast;
  logic                  e_rvalid;
  logic                  e_awready;
  logic                  e_wready;
  logic [ID_WIDTH-1:0]   e_bid;
  logic [1:0]            e_bresp;
  logic                  e_bvalid;

  assign run     = state == RUN && !rst_core;
  assign err     = state == ERROR && !rst_core;
  assign rd_full = rd_cnt == CNT_W'(MAX_OUT);
  assign wr_full = wr_cnt == CNT_W'(MAX_OUT);
  assign ar_hs   = m_arvalid && m_arready;
  assign r_end   = m_rvalid && m_rready && m_rlast;
  assign aw_hs   = m_awvalid && m_awready;
  assign b_end   = m_bvalid && m_bready;

  assign m_awid    = s_awid;
  assign m_awaddr  = s_awaddr;
  assign m_awlen   = s_awlen;
  assign m_awsize  = s_awsize;
  assign m_awburst = s_awburst;
  assign m_awvalid = run && s_awvalid && !wr_full;
  assign s_awready = run ? m_awready && !wr_full : e_awready;
  assign m_wdata   = s_wdata;
  assign m_wstrb   = s_wstrb;
  assign m_wlast   = s_wlast;
  assign m_wvalid  = run && s_wvalid;
  assign s_wready  = run ? m_wready : e_wready;
  assign s_bid     = run ? m_bid : e_bid;
  assign s_bresp   = run ? m_bresp : e_bresp;
  assign s_bvalid  = run ? m_bvalid : e_bvalid;
  assign m_bready  = run && s_bready;
  assign m_arid    = s_arid;
  assign m_araddr  = s_araddr;
  assign m_arlen   = s_arlen;
  assign m_arsize  = s_arsize;
  assign m_arburst = s_arburst;
  assign m_arvalid = run && s_arvalid && !rd_full;
  assign s_arready = run ? m_arready && !rd_full : e_arready;
  assign s_rid     = run ? m_rid : e_rid;
  assign s_rdata   = run ? m_rdata : e_rdata;
  assign s_rresp   = run ? m_rresp : e_rresp;
  assign s_rlast   = run ? m_rlast : e_rlast;
  assign s_rvalid  = run ? m_rvalid : e_rvalid;
  assign m_rready  = run && s_rready;
  assign o_state   = state;

`ifdef INIT_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        tmo_flag;
  assign o_timeout = tmo_flag;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state  <= WAIT_INIT;
      rd_cnt <= '0;
      wr_cnt <= '0;
`ifdef INIT_TIMEOUT_EN
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
`endif
    end else begin
      state  <= state != WAIT_INIT ? state : i_ram_init_error ? ERROR : i_ram_init_done ? RUN : state;
      rd_cnt <= rd_cnt + CNT_W'(ar_hs) - CNT_W'(r_end);
      wr_cnt <= wr_cnt + CNT_W'(aw_hs) - CNT_W'(b_end);
`ifdef INIT_TIMEOUT_EN
      if (state == WAIT_INIT && !i_ram_init_error && !i_ram_init_done) begin
        tmo_cnt <= tmo_cnt + 32'd1;
        if (tmo_cnt == TIMEOUT_CYCLES - 32'd1) begin
          state    <= ERROR;
          tmo_flag <= 1'b1;
        end
      end
`endif
    end
  end

  axi_err_slave #(
    .ID_WIDTH  (ID_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_err (
    .clk_core (clk_core),
    .rst_core (rst_core),
    .en       (err),
    .s_arid   (s_arid),
    .s_arlen  (s_arlen),
    .s_arvalid(s_arvalid),
    .s_arready(e_arready),
    .s_rid    (e_rid),
    .s_rdata  (e_rdata),
    .s_rresp  (e_rresp),
    .s_rlast  (e_rlast),
    .s_rvalid (e_rvalid),
    .s_rready (s_rready),
    .s_awid   (s_awid),
    .s_awvalid(s_awvalid),
    .s_awready(e_awready),
    .s_wlast  (s_wlast),
    .s_wvalid (s_wvalid),
    .s_wready (e_wready),
    .s_bid    (e_bid),
    .s_bresp  (e_bresp),
    .s_bvalid (e_bvalid),
    .s_bready (s_bready)
  );
endmodule

// File: tb/tb_axi_ram_init_gate.sv
// tb_axi_ram_init_gate: directed vector table plus multi-cycle sequences against a small AXI memory model
module tb_axi_ram_init_gate;
  localparam int IW = 6;
  localparam int ADW = 32;
  localparam int DW = 64;
  logic clk_core = 0, rst_core = 1, i_ram_init_done = 0, i_ram_init_error = 0;
  logic [IW-1:0] s_awid = '0, s_arid = '0, s_bid, s_rid, m_awid, m_arid, m_bid = '0, m_rid = '0;
  logic [ADW-1:0] s_awaddr = '0, s_araddr = '0, m_awaddr, m_araddr;
  logic [7:0] s_awlen = '0, s_arlen = '0, m_awlen, m_arlen;
  logic [2:0] s_awsize = 3'd3, s_arsize = 3'd3, m_awsize, m_arsize;
  logic [1:0] s_awburst = 2'd1, s_arburst = 2'd1, m_awburst, m_arburst;
  logic [DW-1:0] s_wdata = '0, m_wdata, s_rdata, m_rdata = '0;
  logic [DW/8-1:0] s_wstrb = '1, m_wstrb;
  logic [1:0] s_bresp, s_rresp, m_bresp = '0, m_rresp = '0, o_state;
  logic s_awvalid = 0, s_awready, s_wlast = 0, s_wvalid = 0, s_wready, s_bvalid, s_bready = 0;
  logic s_arvalid = 0, s_arready, s_rlast, s_rvalid, s_rready = 0;
  logic m_awvalid, m_awready = 0, m_wlast, m_wvalid, m_wready = 0, m_bvalid = 0, m_bready;
  logic m_arvalid, m_arready = 0, m_rlast = 0, m_rvalid = 0, m_rready, o_timeout;
  logic model_en = 0, r_stall = 0, mon_en = 0, mv = 0;
  int vecs = 0, errs = 0;

  always #5 clk_core = ~clk_core;

  axi_ram_init_gate #(.ID_WIDTH(IW), .ADDR_WIDTH(ADW), .DATA_WIDTH(DW), .MAX_OUT(15), .TIMEOUT_CYCLES(32'd20)) dut (
    .clk_core(clk_core), .rst_core(rst_core), .i_ram_init_done(i_ram_init_done), .i_ram_init_error(i_ram_init_error),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready), .o_state(o_state), .o_timeout(o_timeout)
  );

  typedef struct {logic [IW-1:0] id; logic [ADW-1:0] addr; logic [7:0] len;} ar_t;
  typedef struct {bit run; logic [9:0] stim; logic [9:0] exp;} vec_t;
  ar_t arq[$];
  logic [IW-1:0] awq[$], bq[$];
  int beat = 0;
  vec_t tbl[8];

  function automatic logic [DW-1:0] mem(input logic [ADW-1:0] a);
    return {a, ~a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic apply(input vec_t v, input int k);
    {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready, m_awready, m_wready, m_arready, m_bvalid, m_rvalid} = v.stim;
    #2;
    chk($sformatf("vec%0d", k), 64'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
                                      s_awready, s_wready, s_arready, s_bvalid, s_rvalid}), 64'(v.exp));
    {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready, m_awready, m_wready, m_arready, m_bvalid, m_rvalid} = '0;
  endtask

  always @(negedge clk_core)
    if (mon_en && (m_arvalid || m_awvalid || m_wvalid || m_bready || m_rready)) mv <= 1'b1;

  initial begin
    logic ar_hs, r_hs, aw_hs, wl_hs, b_hs;
    logic [IW-1:0] aid;
    ar_t cur;
    forever begin
      @(negedge clk_core);
      ar_hs = m_arvalid && m_arready;
      cur = '{m_arid, m_araddr, m_arlen};
      r_hs = m_rvalid && m_rready;
      aw_hs = m_awvalid && m_awready;
      aid = m_awid;
      wl_hs = m_wvalid && m_wready && m_wlast;
      b_hs = m_bvalid && m_bready;
      @(posedge clk_core);
      #1;
      if (rst_core) begin
        arq.delete();
        awq.delete();
        bq.delete();
        beat = 0;
      end else begin
        if (r_hs && arq.size() > 0) begin
          if (beat == int'(arq[0].len)) begin
            void'(arq.pop_front());
            beat = 0;
          end else beat++;
        end
        if (ar_hs) arq.push_back(cur);
        if (b_hs && bq.size() > 0) void'(bq.pop_front());
        if (aw_hs) awq.push_back(aid);
        if (wl_hs && awq.size() > 0) bq.push_back(awq.pop_front());
      end
      if (model_en) begin
        m_awready = 1;
        m_wready = 1;
        m_arready = 1;
        m_bvalid = bq.size() > 0;
        m_bid = bq.size() > 0 ? bq[0] : '0;
        m_bresp = 2'b00;
        m_rresp = 2'b00;
        m_rvalid = !r_stall && arq.size() > 0;
        if (arq.size() > 0) begin
          m_rid = arq[0].id;
          m_rdata = mem(arq[0].addr + ADW'(beat * 8));
          m_rlast = beat == int'(arq[0].len);
        end else begin
          m_rid = '0;
          m_rdata = '0;
          m_rlast = 0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, nb, nb16, bad, n, nw;
    logic got, early, b_ok, aw_ok, w_ok;
    tbl[0] = '{0, 10'h3FF, 10'h000};
    tbl[1] = '{0, 10'h155, 10'h000};
    tbl[2] = '{0, 10'h2AA, 10'h000};
    tbl[3] = '{1, 10'h3FF, 10'h3FF};
    tbl[4] = '{1, 10'h155, 10'h155};
    tbl[5] = '{1, 10'h2AA, 10'h2AA};
    tbl[6] = '{1, 10'h01F, 10'h01F};
    tbl[7] = '{1, 10'h000, 10'h000};
    // reset state, with traffic offered on both sides
    s_arvalid = 1; m_arready = 1; m_rvalid = 1; s_rready = 1;
    repeat (3) step();
    @(negedge clk_core);
    chk("rst_state", 64'(o_state), 64'd0);
    chk("rst_timeout", 64'(o_timeout), 64'd0);
    chk("rst_arready", 64'(s_arready), 64'd0);
    chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_s_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_m_rready", 64'(m_rready), 64'd0);
    step();
    s_arvalid = 0; m_arready = 0; m_rvalid = 0; s_rready = 0;
    rst_core = 0;
    for (int k = 0; k < 8; k++) if (!tbl[k].run) begin step(); apply(tbl[k], k); end
    // AR held while waiting for init
    step();
    model_en = 1;
    s_arvalid = 1; s_arid = 6'd1; s_araddr = 32'h1000; s_arlen = 8'd1;
    early = 0;
    for (int c = 0; c < 10; c++) begin @(negedge clk_core); if (m_arvalid) early = 1; step(); end
    chk("no_early_ar", 64'(early), 64'd0);
    i_ram_init_done = 1;
    @(negedge clk_core);
    chk("ar_gate_edge", 64'(m_arvalid), 64'd0);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin @(negedge clk_core); if (s_arvalid && s_arready) got = 1; step(); end
    s_arvalid = 0;
    chk("ar_accept", 64'(got), 64'd1);
    chk("state_run", 64'(o_state), 64'd1);
    s_rready = 1;
    n = 0;
    for (int c = 0; c < 30 && n < 2; c++) begin
      @(negedge clk_core);
      if (s_rvalid) begin
        chk("run_rdata", 64'(s_rdata), 64'(mem(32'h1000 + 32'(n * 8))));
        chk("run_rid", 64'(s_rid), 64'd1);
        chk("run_rlast", 64'(s_rlast), 64'(n == 1));
        n++;
      end
    end
    chk("run_r_beats", 64'(n), 64'd2);
    // single write through to the memory model
    step();
    s_awvalid = 1; s_awid = 6'd5; s_awaddr = 32'h2000; s_awlen = 8'd0;
    s_wvalid = 1; s_wlast = 1; s_wdata = 64'hA5A5; s_bready = 1;
    aw_ok = 0; w_ok = 0; b_ok = 0;
    for (int c = 0; c < 20 && !b_ok; c++) begin
      @(negedge clk_core);
      if (s_awvalid && s_awready) aw_ok = 1;
      if (s_wvalid && s_wready) w_ok = 1;
      if (s_bvalid) begin
        b_ok = 1;
        chk("run_bid", 64'(s_bid), 64'd5);
        chk("run_bresp", 64'(s_bresp), 64'd0);
      end
      step();
      if (aw_ok) s_awvalid = 0;
      if (w_ok) s_wvalid = 0;
    end
    chk("run_b_seen", 64'(b_ok), 64'd1);
    s_bready = 0; s_wlast = 0; s_rready = 0;
    // pass-through vectors in RUN
    model_en = 0;
    for (int k = 0; k < 8; k++) if (tbl[k].run) begin step(); apply(tbl[k], k); end
    // outstanding read limit
    step();
    model_en = 1; r_stall = 1; s_rready = 1;
    s_arvalid = 1; s_arid = 6'd2; s_araddr = 32'h4000; s_arlen = 8'd0;
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_core);
      if (s_arvalid && s_arready) acc++;
      step();
      s_araddr = 32'h4000 + 32'(acc * 8);
    end
    chk("ar_cap", 64'(acc), 64'd15);
    @(negedge clk_core);
    chk("ar_full_block", 64'(s_arready), 64'd0);
    chk("ar_full_m", 64'(m_arvalid), 64'd0);
    step();
    r_stall = 0;
    nb = 0; nb16 = -1; bad = 0;
    for (int c = 0; c < 80 && nb < 16; c++) begin
      @(negedge clk_core);
      if (s_arvalid && s_arready) begin acc++; nb16 = nb; end
      if (s_rvalid && s_rready) begin
        if (s_rdata !== mem(32'h4000 + 32'(nb * 8))) bad++;
        nb++;
      end
      step();
      s_araddr = 32'h4000 + 32'(acc * 8);
      if (acc == 16) s_arvalid = 0;
    end
    chk("ar_16th", 64'(acc), 64'd16);
    chk("ar_16th_after_rlast", 64'(nb16), 64'd1);
    chk("r_drain", 64'(nb), 64'd16);
    chk("r_drain_data", 64'(bad), 64'd0);
    s_arvalid = 0; s_rready = 0;
    // init timeout
    rst_core = 1; i_ram_init_done = 0;
    repeat (2) step();
    rst_core = 0;
`ifdef INIT_TIMEOUT_EN
    repeat (19) step();
    @(negedge clk_core);
    chk("tmo_before", 64'(o_state), 64'd0);
    step();
    @(negedge clk_core);
    chk("tmo_state", 64'(o_state), 64'd2);
    chk("tmo_flag", 64'(o_timeout), 64'd1);
`else
    repeat (40) step();
    @(negedge clk_core);
    chk("no_tmo_state", 64'(o_state), 64'd0);
    chk("no_tmo_flag", 64'(o_timeout), 64'd0);
`endif
    // ERROR entry with done and error together
    rst_core = 1;
    repeat (2) step();
    rst_core = 0;
    mv = 0; mon_en = 1;
    repeat (5) step();
    i_ram_init_error = 1; i_ram_init_done = 1;
    @(negedge clk_core);
    chk("err_pre", 64'(o_state), 64'd0);
    step();
    @(negedge clk_core);
    chk("err_wins", 64'(o_state), 64'd2);
    chk("err_no_tmo", 64'(o_timeout), 64'd0);
    step();
    s_arvalid = 1; s_arid = 6'd3; s_arlen = 8'd3; s_rready = 0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin @(negedge clk_core); if (s_arvalid && s_arready) got = 1; step(); end
    chk("err_ar_acc", 64'(got), 64'd1);
    s_arid = 6'd9;
    @(negedge clk_core);
    chk("err_ar_busy", 64'(s_arready), 64'd0);
    step();
    s_arvalid = 0;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk_core);
      if (s_rvalid && s_rready) begin
        chk("err_rresp", 64'(s_rresp), 64'd2);
        chk("err_rid", 64'(s_rid), 64'd3);
        chk("err_rdata", 64'(s_rdata), 64'd0);
        chk("err_rlast", 64'(s_rlast), 64'(n == 3));
        n++;
      end
      step();
      s_rready = (c % 2 == 0);
    end
    s_rready = 0;
    chk("err_r_beats", 64'(n), 64'd4);
    @(negedge clk_core);
    chk("err_r_done", 64'(s_rvalid), 64'd0);
    chk("err_ar_idle", 64'(s_arready), 64'd1);
    // error write path, W offered before AW
    step();
    s_wvalid = 1; s_wlast = 0;
    @(negedge clk_core);
    chk("err_w_hold", 64'(s_wready), 64'd0);
    step();
    s_awvalid = 1; s_awid = 6'd7; s_awlen = 8'd1;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin @(negedge clk_core); if (s_awvalid && s_awready) got = 1; step(); end
    s_awvalid = 0;
    chk("err_aw_acc", 64'(got), 64'd1);
    nw = 0;
    for (int c = 0; c < 10 && nw < 2; c++) begin
      @(negedge clk_core);
      if (s_wvalid && s_wready) nw++;
      step();
      s_wlast = (nw == 1);
      if (nw == 2) s_wvalid = 0;
    end
    s_wlast = 0;
    chk("err_w_beats", 64'(nw), 64'd2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_core);
      chk("err_bvalid_hold", 64'(s_bvalid), 64'd1);
      chk("err_bresp", 64'(s_bresp), 64'd2);
      chk("err_bid", 64'(s_bid), 64'd7);
      step();
    end
    s_bready = 1;
    @(negedge clk_core);
    chk("err_bvalid_hs", 64'(s_bvalid), 64'd1);
    step();
    s_bready = 0;
    @(negedge clk_core);
    chk("err_b_cleared", 64'(s_bvalid), 64'd0);
    mon_en = 0;
    chk("err_no_m_traffic", 64'(mv), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/axi_ram_init_gate.md
AXI_RAM_INIT_GATE -- requirements
Module: axi_ram_init_gate

Interface
REQ-001 The block SHALL have a parameter ID_WIDTH, default 6, giving the AXI ID width.
REQ-002 The block SHALL have a parameter ADDR_WIDTH, default 32, giving the AXI address width.
REQ-003 The block SHALL have a parameter DATA_WIDTH, default 64, giving the AXI data width; strobe width is DATA_WIDTH/8.
REQ-004 The block SHALL have a parameter MAX_OUT, default 15, giving the per-direction outstanding-burst limit (1..255).
REQ-005 The block SHALL have a parameter TIMEOUT_CYCLES, default 32'd100_000_000, giving the init-wait limit when INIT_TIMEOUT_EN is defined.
REQ-006 Ports SHALL be:
- clk_core  in  1  sole clock; one clock; reset is synchronous and active-high.
- rst_core  in  1  synchronous active-high reset.
- i_ram_init_done  in  1  memory controller calibration complete.
- i_ram_init_error  in  1  memory controller calibration failed.
- s_aw*/s_w*/s_b*/s_ar*/s_r*  slave  per AXI4  CPU-side channels: id, addr, len[7:0], size[2:0], burst[1:0], valid/ready, wdata, wstrb, wlast, bresp, rdata, rresp, rlast.
- m_aw*/m_w*/m_b*/m_ar*/m_r*  master  per AXI4  same set, toward the clock-domain crossing and DRAM.
- o_state  out  2  00 WAIT_INIT, 01 RUN, 10 ERROR.
- o_timeout  out  1  sticky; ERROR was entered by timeout.

Function
REQ-007 The FSM SHALL be: WAIT_INIT -> RUN when init_done=1 and init_error=0; WAIT_INIT -> ERROR when init_error=1, and error wins if both are set in the same cycle; RUN and ERROR are terminal until reset.
REQ-008 In WAIT_INIT, all s_*ready, s_bvalid, s_rvalid and m_*valid SHALL be 0.
REQ-009 In RUN, every channel SHALL pass through combinationally with zero latency, except AR and AW gating.
REQ-010 In RUN, an 8-bit read counter SHALL +1 on an m_ar handshake and -1 on an m_r handshake with rlast=1; both in the same cycle leaves it unchanged.
REQ-011 In RUN, s_arready and m_arvalid SHALL be forced to 0 while the read counter equals MAX_OUT.
REQ-012 In RUN, a write counter SHALL count m_aw handshakes up and m_b handshakes down, with the same rules applied to the AW channel.
REQ-013 In ERROR, m_*valid, m_bready and m_rready SHALL be 0 and the slave side SHALL be terminated locally.
REQ-014 ERROR read path: accept one AR when idle (s_arready=1), latch id and len, then issue len+1 R beats. Each beat has rdata=0, rresp=2'b10 (SLVERR), rid=latched id, and rlast on the final beat. A beat advances only on s_rready. No new AR is accepted until the last beat completes.
REQ-015 ERROR write path: accept one AW, latch id, drive s_wready=1 and discard beats until a beat with wlast=1, then raise s_bvalid with bresp=2'b10 until s_bready. W beats arriving before the AW are held off with s_wready=0.
REQ-016 ERROR read and write paths SHALL operate independently and concurrently.
REQ-017 Bursts already in flight on entry to ERROR cannot occur, because RUN is never left.

Reset
REQ-018 While rst_core=1, state SHALL be WAIT_INIT, counters and burst counters 0, o_timeout 0, and all valid/ready outputs 0; the first cycle after release evaluates the REQ-007 transitions.

Configuration
REQ-019 With INIT_TIMEOUT_EN defined, a 32-bit counter SHALL count WAIT_INIT cycles, and reaching TIMEOUT_CYCLES SHALL enter ERROR and set o_timeout.
REQ-020 Without INIT_TIMEOUT_EN, WAIT_INIT SHALL persist indefinitely, o_timeout SHALL be tied 0, and no timeout counter SHALL exist.

Structure
REQ-021 Package axi_ram_init_gate_pkg SHALL hold the state enum (WAIT_INIT, RUN, ERROR), RESP_SLVERR=2'b10 and the counter width constant.
REQ-022 Sub-module axi_err_slave SHALL implement the REQ-014/015 local error responder; the gate FSM and counters stay in the top.

Verification
REQ-023 Reset, init_done=1 at cycle 10 with s_arvalid held from cycle 0 -> no m_arvalid before cycle 11, then pass-through, and the read data matches the memory model.
REQ-024 Issue 16 back-to-back ARs len=0 with the memory model stalling R -> 15 accepted, s_arready=0 on the 16th until one rlast handshake.
REQ-025 init_error=1 at cycle 5, then AR id=3 len=3 -> exactly 4 R beats with rresp=2'b10, rid=3, rlast only on beat 4, and m_arvalid never set.
REQ-026 In ERROR, AW id=7 len=1, two W beats with wlast on the second, s_bready held 0 for 3 cycles -> s_bvalid held with bresp=2'b10 and bid=7 until the ready handshake.
REQ-027 With INIT_TIMEOUT_EN and TIMEOUT_CYCLES=20, init_done never asserted -> o_state=10 and o_timeout=1 at cycle 20 after reset release.
